jogo_memoria_param: RTL

- Parametrised memory-game unit: FSM and datapath in one block, with a growing-sequence mode.
- Round r requires the player to repeat sequence entries 0..r.
- Each play is an N_BOTOES-wide one-hot button vector, edge-detected, registered and compared against an external sequence memory.
- Per-play inactivity timeout; final verdict held until a new start.
- Sits between board buttons/LEDs and an asynchronous sequence ROM.

---
 rtl/jogo_pkg.sv | 38 +++
 rtl/contador_m.sv | 41 ++++
 rtl/jogo_memoria_param.sv | 132 +++++++++++++
 3 files changed

// File: rtl/jogo_pkg.sv
// Shared definitions for the memory game: state codes and a one-hot check.
package jogo_pkg;

    localparam int unsigned EST_W = 4;

    localparam logic [EST_W-1:0] COD_IDLE        = 4'd0;
    localparam logic [EST_W-1:0] COD_PREPARA     = 4'd1;
    localparam logic [EST_W-1:0] COD_NOVA_RODADA = 4'd2;
    localparam logic [EST_W-1:0] COD_ESPERA      = 4'd3;
    localparam logic [EST_W-1:0] COD_COMPARA     = 4'd4;
    localparam logic [EST_W-1:0] COD_PROX_JOGADA = 4'd5;
    localparam logic [EST_W-1:0] COD_PROX_RODADA = 4'd6;
    localparam logic [EST_W-1:0] COD_FIM_ACERTO  = 4'd7;
    localparam logic [EST_W-1:0] COD_FIM_ERRO    = 4'd8;
    localparam logic [EST_W-1:0] COD_FIM_TIMEOUT = 4'd9;

    typedef enum logic [EST_W-1:0] {
        IDLE        = COD_IDLE,
        PREPARA     = COD_PREPARA,
        NOVA_RODADA = COD_NOVA_RODADA,
        ESPERA      = COD_ESPERA,
        COMPARA     = COD_COMPARA,
        PROX_JOGADA = COD_PROX_JOGADA,
        PROX_RODADA = COD_PROX_RODADA,
        FIM_ACERTO  = COD_FIM_ACERTO,
        FIM_ERRO    = COD_FIM_ERRO,
        FIM_TIMEOUT = COD_FIM_TIMEOUT
    } estado_t;

    // Widest play vector the one-hot check accepts.
    localparam int unsigned ONEHOT_MAX_W = 32;

    // True when exactly one bit of v is set.
    function automatic logic eh_one_hot(input logic [ONEHOT_MAX_W-1:0] v);
        return (v != '0) && ((v & (v - ONEHOT_MAX_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/contador_m.sv
// Modulus-M cycle counter with synchronous clear; fim/meio track the count.
module contador_m #(
    parameter int unsigned M = 5000
) (
    input  logic clock,
    input  logic reset,
    input  logic zera_s,
    input  logic conta,
    output logic fim,
    output logic meio
);

    localparam int unsigned W = (M > 1) ? $clog2(M) : 1;

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_next;

    // Next count: clear wins over count; wraps at M-1.
    always_comb begin
        cnt_next = cnt;
        if (zera_s) begin
            cnt_next = '0;
        end else if (conta) begin
            cnt_next = (cnt == W'(M - 1)) ? '0 : cnt + W'(1);
        end
    end

    // Count register; flags registered from the next count so they match cnt.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            fim  <= 1'b0;
            meio <= 1'b0;
        end else begin
            cnt  <= cnt_next;
            fim  <= (cnt_next == W'(M - 1));
            meio <= (cnt_next >= W'(M / 2));
        end
    end

endmodule

// File: rtl/jogo_memoria_param.sv
// Memory game: growing-sequence FSM with play edge detection and per-play timeout.
module jogo_memoria_param
    import jogo_pkg::*;
#(
    parameter int unsigned N_BOTOES  = 4,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned T_TIMEOUT = 5000,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic [N_BOTOES-1:0] botoes,
    output logic [AW-1:0]       mem_addr,
    input  logic [N_BOTOES-1:0] mem_data,
    output logic                pronto,
    output logic                acertou,
    output logic                errou,
    output logic                timeout,
    output logic [EST_W-1:0]    db_estado,
    output logic [AW-1:0]       db_rodada,
    output logic [N_BOTOES-1:0] db_jogada,
    output logic                db_timer_meio
);

    estado_t             estado;
    estado_t             estado_next;
    logic [AW-1:0]       addr;
    logic [AW-1:0]       limite;
    logic [N_BOTOES-1:0] jogada;
    logic                prev;
    logic                jogada_feita;
    logic                timer_fim;
    logic                timer_zera;
    logic                timer_conta;

    // One pulse per press, however long the button is held.
    assign jogada_feita = (|botoes) & ~prev;

    assign timer_zera  = (estado == NOVA_RODADA) || (estado == PROX_JOGADA);
    assign timer_conta = (estado == ESPERA);

    contador_m #(
        .M (T_TIMEOUT)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .zera_s (timer_zera),
        .conta  (timer_conta),
        .fim    (timer_fim),
        .meio   (db_timer_meio)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= IDLE;
        end else begin
            estado <= estado_next;
        end
    end

    // Next-state logic; a press on the expiry cycle takes priority over timeout.
    always_comb begin
        estado_next = estado;
        case (estado)
            IDLE:        if (iniciar) estado_next = PREPARA;
            PREPARA:     estado_next = NOVA_RODADA;
            NOVA_RODADA: estado_next = ESPERA;
            ESPERA: begin
                if (jogada_feita)   estado_next = COMPARA;
                else if (timer_fim) estado_next = FIM_TIMEOUT;
            end
            COMPARA: begin
                if ((jogada != mem_data) || !eh_one_hot(ONEHOT_MAX_W'(jogada)))
                    estado_next = FIM_ERRO;
                else if (addr < limite)
                    estado_next = PROX_JOGADA;
                else if (limite == AW'(DEPTH - 1))
                    estado_next = FIM_ACERTO;
                else
                    estado_next = PROX_RODADA;
            end
            PROX_JOGADA: estado_next = ESPERA;
            PROX_RODADA: estado_next = NOVA_RODADA;
            FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: if (iniciar) estado_next = PREPARA;
            default:     estado_next = IDLE;
        endcase
    end

    // Datapath: edge-detector history, play capture, play and round counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev   <= 1'b0;
            jogada <= '0;
            addr   <= '0;
            limite <= '0;
        end else begin
            prev <= |botoes;
            if ((estado == ESPERA) && jogada_feita) jogada <= botoes;
            case (estado)
                PREPARA:     limite <= '0;
                NOVA_RODADA: addr   <= '0;
                PROX_JOGADA: addr   <= addr + AW'(1);
                PROX_RODADA: limite <= limite + AW'(1);
                default:     ;
            endcase
        end
    end

    // Verdict flags registered from the next state so they change with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pronto  <= 1'b0;
            acertou <= 1'b0;
            errou   <= 1'b0;
            timeout <= 1'b0;
        end else begin
            pronto  <= (estado_next == FIM_ACERTO) || (estado_next == FIM_ERRO) ||
                       (estado_next == FIM_TIMEOUT);
            acertou <= (estado_next == FIM_ACERTO);
            errou   <= (estado_next == FIM_ERRO);
            timeout <= (estado_next == FIM_TIMEOUT);
        end
    end

    assign mem_addr  = addr;
    assign db_estado = estado;
    assign db_rodada = limite;
    assign db_jogada = jogada;

endmodule
